// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battle_pkg
// Description : Shared definitions for the battle-screen turn sequencer:
//               FSM state encoding, PS/2 attack key codes, LFSR seed/taps
//               and a saturating 8-bit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package battle_pkg;

  // FSM state encoding (explicit 4-bit width)
  typedef logic [3:0] battle_state_t;

  localparam battle_state_t ST_IDLE     = 4'd0;
  localparam battle_state_t ST_INIT     = 4'd1;
  localparam battle_state_t ST_SETTLE_I = 4'd2;
  localparam battle_state_t ST_P_WAIT   = 4'd3;
  localparam battle_state_t ST_P_REQ    = 4'd4;
  localparam battle_state_t ST_CHECK_P  = 4'd5;
  localparam battle_state_t ST_E_CHOOSE = 4'd6;
  localparam battle_state_t ST_E_REQ    = 4'd7;
  localparam battle_state_t ST_CHECK_E  = 4'd8;
  localparam battle_state_t ST_WON      = 4'd9;
  localparam battle_state_t ST_LOST     = 4'd10;

  // PS/2 make codes for the three attack keys ('1', '2', '3')
  localparam logic [7:0] KEY_ATK1 = 8'h16;
  localparam logic [7:0] KEY_ATK2 = 8'h1E;
  localparam logic [7:0] KEY_ATK3 = 8'h26;

  // Galois LFSR, x^8+x^6+x^5+x^4+1, right-shifting: bit i stands for x^(i+1)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Clamp a wide unsigned value into an 8-bit damage amount
  function automatic logic [7:0] sat8(input logic [15:0] v);
    if (v > 16'd255) begin
      return 8'hFF;
    end
    return v[7:0];
  endfunction

endpackage : battle_pkg
`default_nettype wire

// File: rtl/battle_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : battle_lfsr
// Description : Free-running 8-bit Galois LFSR used as a cheap random source
//               for game logic. Advances on every rising clock edge.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset (loads LFSR_SEED)
//               lfsr_o - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module battle_lfsr
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift right; when a 1 falls out of bit 0, fold it back in at the taps
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]};
    if (lfsr_q[0]) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule : battle_lfsr
`default_nettype wire

// File: rtl/battle_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : battle_turn_ctrl
// Description : Battle-screen turn sequencer. Starts a battle on enemy
//               collision, alternates player/enemy turns, issues damage
//               requests to the HP datapath over valid/ready, and reports
//               win/loss when an HP value reaches zero. Owns no HP state.
// Config      : BATTLE_CRIT_EN - when defined, player hits with
//               lfsr[7:5]==3'b111 deal double damage and the extra output
//               'crit' flags that request.
// Ports       : clk_b, rst            - clock, async active-high reset
//               col_e, boss           - collision level, boss qualifier
//               key_valid, key_in     - keyboard strobe and make code
//               hp_player, hp_enemy   - HP values from the datapath
//               init_valid, init_boss - HP reload pulse and boss qualifier
//               dmg_valid/ready, dmg_to_enemy, dmg_amount - damage request
//               p_attack, e_attack    - last attack numbers
//               battle_active/won/lost - battle status
// Revision    : 1.0 - initial release
// ============================================================================
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int P_DMG1     = 10,
  parameter int P_DMG2     = 20,
  parameter int P_DMG3     = 30,
  parameter int E_DMG_BASE = 8,
  parameter int BOSS_BONUS = 4
) (
  input  logic       clk_b,
  input  logic       rst,
  input  logic       col_e,
  input  logic       boss,
  input  logic       key_valid,
  input  logic [7:0] key_in,
  input  logic [7:0] hp_player,
  input  logic [7:0] hp_enemy,
  output logic       init_valid,
  output logic       init_boss,
  output logic       dmg_valid,
  input  logic       dmg_ready,
  output logic       dmg_to_enemy,
  output logic [7:0] dmg_amount,
  output logic [2:0] p_attack,
  output logic [2:0] e_attack,
  output logic       battle_active,
  output logic       battle_won,
  output logic       battle_lost
`ifdef BATTLE_CRIT_EN
  ,
  output logic       crit
`endif
);

  // --------------------------------------------------------------------------
  // Random source
  // --------------------------------------------------------------------------
  logic [7:0] w_lfsr;

  battle_lfsr u_lfsr (
    .clk    (clk_b),
    .rst    (rst),
    .lfsr_o (w_lfsr)
  );

  // Bits 4:3 never steer anything; bits 7:5 only matter with crits enabled
  logic w_unused_lfsr;
  assign w_unused_lfsr = ^w_lfsr[7:3];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  battle_state_t state_q, state_d;
  logic          boss_q, boss_d;
  logic [7:0]    amount_q, amount_d;
  logic [2:0]    p_attack_q, p_attack_d;
  logic [2:0]    e_attack_q, e_attack_d;
`ifdef BATTLE_CRIT_EN
  logic          crit_q, crit_d;
`endif

  // --------------------------------------------------------------------------
  // Player attack decode and hit resolution
  // --------------------------------------------------------------------------
  logic [2:0]  w_key_atk;
  logic        w_key_hit;
  logic [15:0] w_p_raw;
  logic [7:0]  w_p_amt;
  logic        w_crit;

  always_comb begin
    w_key_atk = 3'd0;
    case (key_in)
      KEY_ATK1: w_key_atk = 3'd1;
      KEY_ATK2: w_key_atk = 3'd2;
      KEY_ATK3: w_key_atk = 3'd3;
      default:  w_key_atk = 3'd0;
    endcase

    // Attack 1 is reliable; the heavier attacks trade accuracy for damage
    w_key_hit = 1'b0;
    w_p_raw   = 16'd0;
    case (w_key_atk)
      3'd1: begin
        w_key_hit = 1'b1;
        w_p_raw   = P_DMG1[15:0];
      end
      3'd2: begin
        w_key_hit = (w_lfsr[1:0] != 2'b00);
        w_p_raw   = P_DMG2[15:0];
      end
      3'd3: begin
        w_key_hit = w_lfsr[0];
        w_p_raw   = P_DMG3[15:0];
      end
      default: begin
        w_key_hit = 1'b0;
        w_p_raw   = 16'd0;
      end
    endcase

`ifdef BATTLE_CRIT_EN
    w_crit = w_key_hit && (w_lfsr[7:5] == 3'b111);
`else
    w_crit = 1'b0;
`endif
    w_p_amt = w_crit ? sat8({w_p_raw[14:0], 1'b0}) : sat8(w_p_raw);
  end

  // --------------------------------------------------------------------------
  // Enemy attack choice: lfsr[2:1] of 0 and 1 both map to attack 1
  // --------------------------------------------------------------------------
  logic [1:0]  w_e_sel;
  logic [2:0]  w_e_atk;
  logic [15:0] w_e_raw;

  assign w_e_sel = w_lfsr[2:1];
  assign w_e_atk = (w_e_sel == 2'd0) ? 3'd1 : {1'b0, w_e_sel};
  assign w_e_raw = (E_DMG_BASE[15:0] * {13'd0, w_e_atk})
                 + (boss_q ? BOSS_BONUS[15:0] : 16'd0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    boss_d     = boss_q;
    amount_d   = amount_q;
    p_attack_d = p_attack_q;
    e_attack_d = e_attack_q;
`ifdef BATTLE_CRIT_EN
    crit_d     = crit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Latch the enemy type at the collision so it is stable all battle
        if (col_e) begin
          boss_d  = boss;
          state_d = ST_INIT;
        end
      end

      ST_INIT:     state_d = ST_SETTLE_I;

      ST_SETTLE_I: state_d = ST_P_WAIT;

      ST_P_WAIT: begin
        if (key_valid && (w_key_atk != 3'd0)) begin
          if (w_key_hit) begin
            p_attack_d = w_key_atk;
            amount_d   = w_p_amt;
`ifdef BATTLE_CRIT_EN
            crit_d     = w_crit;
`endif
            state_d    = ST_P_REQ;
          end else begin
            p_attack_d = 3'd0;
            state_d    = ST_E_CHOOSE;
          end
        end
      end

      ST_P_REQ: begin
        if (dmg_ready) begin
          state_d = ST_CHECK_P;
        end
      end

      // HP was updated on the transfer edge, so it is valid here
      ST_CHECK_P: state_d = (hp_enemy == 8'd0) ? ST_WON : ST_E_CHOOSE;

      ST_E_CHOOSE: begin
        e_attack_d = w_e_atk;
        amount_d   = sat8(w_e_raw);
`ifdef BATTLE_CRIT_EN
        crit_d     = 1'b0;
`endif
        state_d    = ST_E_REQ;
      end

      ST_E_REQ: begin
        if (dmg_ready) begin
          state_d = ST_CHECK_E;
        end
      end

      ST_CHECK_E: state_d = (hp_player == 8'd0) ? ST_LOST : ST_P_WAIT;

      ST_WON, ST_LOST: begin
        if (key_valid) begin
          p_attack_d = 3'd0;
          e_attack_d = 3'd0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      boss_q     <= 1'b0;
      amount_q   <= 8'd0;
      p_attack_q <= 3'd0;
      e_attack_q <= 3'd0;
`ifdef BATTLE_CRIT_EN
      crit_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      boss_q     <= boss_d;
      amount_q   <= amount_d;
      p_attack_q <= p_attack_d;
      e_attack_q <= e_attack_d;
`ifdef BATTLE_CRIT_EN
      crit_q     <= crit_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from the state register so an async reset clears them
  // immediately. The amount is gated so it reads 0 outside a request.
  // --------------------------------------------------------------------------
  assign init_valid    = (state_q == ST_INIT);
  assign init_boss     = (state_q == ST_INIT) && boss_q;
  assign dmg_valid     = (state_q == ST_P_REQ) || (state_q == ST_E_REQ);
  assign dmg_to_enemy  = (state_q == ST_P_REQ);
  assign dmg_amount    = dmg_valid ? amount_q : 8'd0;
  assign p_attack      = p_attack_q;
  assign e_attack      = e_attack_q;
  assign battle_active = (state_q != ST_IDLE);
  assign battle_won    = (state_q == ST_WON);
  assign battle_lost   = (state_q == ST_LOST);
`ifdef BATTLE_CRIT_EN
  assign crit          = (state_q == ST_P_REQ) && crit_q;
`endif

endmodule : battle_turn_ctrl
`default_nettype wire

// File: tb/tb_battle_turn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_battle_turn_ctrl
// Description : Directed self-checking bench for battle_turn_ctrl. Inputs
//               change and outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battle_turn_ctrl;

  logic       clk_b = 1'b0;
  logic       rst = 1'b1;
  logic       col_e = 1'b0;
  logic       boss = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic [7:0] hp_player = 8'd100;
  logic [7:0] hp_enemy = 8'd100;
  logic       dmg_ready = 1'b0;
  logic       init_valid, init_boss, dmg_valid, dmg_to_enemy;
  logic [7:0] dmg_amount;
  logic [2:0] p_attack, e_attack;
  logic       battle_active, battle_won, battle_lost;
`ifdef BATTLE_CRIT_EN
  logic       crit;
`endif

  int checks = 0;
  int errors = 0;

  battle_turn_ctrl dut (
    .clk_b         (clk_b),
    .rst           (rst),
    .col_e         (col_e),
    .boss          (boss),
    .key_valid     (key_valid),
    .key_in        (key_in),
    .hp_player     (hp_player),
    .hp_enemy      (hp_enemy),
    .init_valid    (init_valid),
    .init_boss     (init_boss),
    .dmg_valid     (dmg_valid),
    .dmg_ready     (dmg_ready),
    .dmg_to_enemy  (dmg_to_enemy),
    .dmg_amount    (dmg_amount),
    .p_attack      (p_attack),
    .e_attack      (e_attack),
    .battle_active (battle_active),
    .battle_won    (battle_won),
    .battle_lost   (battle_lost)
`ifdef BATTLE_CRIT_EN
    ,
    .crit          (crit)
`endif
  );

  always #5 clk_b = ~clk_b;

  // Every output in one vector for "all zero" checks
  logic [20:0] all_o;
  assign all_o = {init_valid, init_boss, dmg_valid, dmg_to_enemy, dmg_amount,
                  p_attack, e_attack, battle_active, battle_won, battle_lost};

  // Reference LFSR: x^8+x^6+x^5+x^4+1 in right-shift Galois form, seed A5
  logic [7:0] m_lfsr;
  always @(posedge clk_b or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= m_lfsr[0] ? ({1'b0, m_lfsr[7:1]} ^ 8'hB8)
                                 : {1'b0, m_lfsr[7:1]};
  end

  task automatic tick();
    @(negedge clk_b);
  endtask

  function automatic logic [2:0] enemy_atk(input logic [7:0] lf);
    logic [1:0] s;
    s = lf[2:1];
    return (s == 2'd0) ? 3'd1 : {1'b0, s};
  endfunction

  function automatic logic [7:0] player_amt(input logic [7:0] base, input logic [7:0] lf);
    logic [8:0] v;
    v = {1'b0, base};
`ifdef BATTLE_CRIT_EN
    if (lf[7:5] == 3'b111) v = {base, 1'b0};
`else
    if (lf[7:5] == 3'b111 && 1'b0) v = {base, 1'b0};
`endif
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (all_o !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000000", all_o);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (all_o !== 21'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h expected 000000", all_o);
    end
  endtask

  // Ends on the falling edge of the first P_WAIT cycle
  task automatic test_battle_start(input logic is_boss);
    col_e = 1'b1;
    boss  = is_boss;
    tick();  // INIT
    checks++;
    if ({init_valid, init_boss, battle_active, dmg_valid} !== {1'b1, is_boss, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL init_pulse: got %b expected %b",
               {init_valid, init_boss, battle_active, dmg_valid}, {1'b1, is_boss, 2'b10});
    end
    col_e = 1'b0;
    tick();  // SETTLE_I
    checks++;
    if ({init_valid, init_boss, battle_active} !== 3'b001) begin
      errors++;
      $display("FAIL init_one_cycle: got %b expected 001",
               {init_valid, init_boss, battle_active});
    end
    boss = 1'b0;
    tick();  // P_WAIT
  endtask

  task automatic test_player_attack1();
    logic [7:0] lf, exp_p;
    logic [2:0] ea;
    lf = m_lfsr;
    exp_p = player_amt(8'd10, lf);
    key_in = 8'h16; key_valid = 1'b1; dmg_ready = 1'b1;
    tick();  // P_REQ
    key_valid = 1'b0;
    checks++;
    if ({dmg_valid, dmg_to_enemy, dmg_amount, p_attack} !== {2'b11, exp_p, 3'd1}) begin
      errors++;
      $display("FAIL p1_request: valid/to_enemy/amount/p_attack got %b/%b/%0d/%0d expected 1/1/%0d/1",
               dmg_valid, dmg_to_enemy, dmg_amount, p_attack, exp_p);
    end
`ifdef BATTLE_CRIT_EN
    checks++;
    if (crit !== (lf[7:5] == 3'b111)) begin
      errors++;
      $display("FAIL p1_crit: got %b expected %b", crit, (lf[7:5] == 3'b111));
    end
`endif
    tick();  // CHECK_P
    checks++;
    if (dmg_valid !== 1'b0) begin
      errors++;
      $display("FAIL p1_single_cycle: dmg_valid got %b expected 0", dmg_valid);
    end
    tick();  // E_CHOOSE
    lf = m_lfsr;
    ea = enemy_atk(lf);
    tick();  // E_REQ
    checks++;
    if ({dmg_valid, dmg_to_enemy, dmg_amount, e_attack} !== {2'b10, ({5'd0, ea} * 8'd8) + 8'd4, ea}) begin
      errors++;
      $display("FAIL e_request_boss: valid/to_enemy/amount/e_attack got %b/%b/%0d/%0d expected 1/0/%0d/%0d",
               dmg_valid, dmg_to_enemy, dmg_amount, e_attack, ({5'd0, ea} * 8'd8) + 8'd4, ea);
    end
    tick();  // CHECK_E
    tick();  // P_WAIT
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_p;
    int guard, xfers;
    guard = 0;
    while (m_lfsr[1:0] == 2'b00 && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      checks++; errors++;
      $display("FAIL bp_wait_timeout: got %0d cycles expected < 64", guard);
    end
    exp_p = player_amt(8'd20, m_lfsr);
    key_in = 8'h1E; key_valid = 1'b1; dmg_ready = 1'b0;
    tick();  // P_REQ
    key_valid = 1'b0;
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({dmg_valid, dmg_to_enemy, dmg_amount, p_attack} !== {2'b11, exp_p, 3'd2}) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid/to_enemy/amount/p_attack got %b/%b/%0d/%0d expected 1/1/%0d/2",
                 i, dmg_valid, dmg_to_enemy, dmg_amount, p_attack, exp_p);
      end
      // a key during the request must be ignored, not queued
      key_in = 8'h16;
      key_valid = (i == 1);
      tick();
    end
    key_valid = 1'b0;
    dmg_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (dmg_valid && dmg_ready && dmg_to_enemy) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 1) begin
      errors++;
      $display("FAIL bp_one_transfer: transfers got %0d expected 1", xfers);
    end
    // now in E_REQ
    checks++;
    if ({dmg_valid, dmg_to_enemy} !== 2'b10) begin
      errors++;
      $display("FAIL bp_enemy_turn: valid/to_enemy got %b expected 10", {dmg_valid, dmg_to_enemy});
    end
    tick();  // CHECK_E
    tick();  // P_WAIT
    tick();  // still P_WAIT: the earlier key was dropped
    checks++;
    if ({dmg_valid, battle_active} !== 2'b01) begin
      errors++;
      $display("FAIL bp_no_queue: valid/active got %b expected 01", {dmg_valid, battle_active});
    end
  endtask

  task automatic test_miss();
    logic [7:0] lf;
    logic [2:0] ea;
    int guard;
    key_in = 8'h1C; key_valid = 1'b1;  // not an attack key
    tick();
    key_valid = 1'b0;
    tick();
    checks++;
    if ({dmg_valid, p_attack} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL ignored_key: valid/p_attack got %b/%0d expected 0/2", dmg_valid, p_attack);
    end
    guard = 0;
    while (m_lfsr[0] == 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      checks++; errors++;
      $display("FAIL miss_wait_timeout: got %0d cycles expected < 64", guard);
    end
    key_in = 8'h26; key_valid = 1'b1;
    tick();  // E_CHOOSE
    key_valid = 1'b0;
    lf = m_lfsr;
    ea = enemy_atk(lf);
    checks++;
    if ({dmg_valid, p_attack} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL miss_no_request: valid/p_attack got %b/%0d expected 0/0", dmg_valid, p_attack);
    end
    tick();  // E_REQ
    checks++;
    if ({dmg_valid, dmg_to_enemy, dmg_amount} !== {2'b10, ({5'd0, ea} * 8'd8) + 8'd4}) begin
      errors++;
      $display("FAIL miss_enemy_req: valid/to_enemy/amount got %b/%b/%0d expected 1/0/%0d",
               dmg_valid, dmg_to_enemy, dmg_amount, ({5'd0, ea} * 8'd8) + 8'd4);
    end
    tick();  // CHECK_E
    tick();  // P_WAIT
  endtask

  task automatic test_win();
    key_in = 8'h16; key_valid = 1'b1; dmg_ready = 1'b1;
    tick();  // P_REQ
    key_valid = 1'b0;
    hp_enemy = 8'd0;
    tick();  // CHECK_P
    tick();  // WON
    col_e = 1'b1;  // must be ignored while the battle is active
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({battle_won, battle_lost, battle_active, dmg_valid, init_valid} !== 5'b10100) begin
        errors++;
        $display("FAIL won_hold_%0d: won/lost/active/valid/init got %b expected 10100",
                 i, {battle_won, battle_lost, battle_active, dmg_valid, init_valid});
      end
      tick();
    end
    key_in = 8'h5A; key_valid = 1'b1; boss = 1'b0;
    tick();  // IDLE
    key_valid = 1'b0;
    checks++;
    if (all_o !== 21'd0) begin
      errors++;
      $display("FAIL won_ack_idle: got %h expected 000000", all_o);
    end
    tick();  // INIT: col_e still high restarts
    checks++;
    if ({init_valid, init_boss, battle_active} !== 3'b101) begin
      errors++;
      $display("FAIL restart_init: got %b expected 101", {init_valid, init_boss, battle_active});
    end
    col_e = 1'b0;
    hp_enemy = 8'd100;
    tick();  // SETTLE_I
    tick();  // P_WAIT
  endtask

  task automatic test_lose();
    logic [7:0] lf;
    logic [2:0] ea;
    key_in = 8'h16; key_valid = 1'b1; dmg_ready = 1'b1;
    tick();  // P_REQ
    key_valid = 1'b0;
    tick();  // CHECK_P
    tick();  // E_CHOOSE
    lf = m_lfsr;
    ea = enemy_atk(lf);
    tick();  // E_REQ
    checks++;
    if ({dmg_valid, dmg_to_enemy, dmg_amount, e_attack} !== {2'b10, {5'd0, ea} * 8'd8, ea}) begin
      errors++;
      $display("FAIL e_request_normal: valid/to_enemy/amount/e_attack got %b/%b/%0d/%0d expected 1/0/%0d/%0d",
               dmg_valid, dmg_to_enemy, dmg_amount, e_attack, {5'd0, ea} * 8'd8, ea);
    end
    hp_player = 8'd0;
    tick();  // CHECK_E
    tick();  // LOST
    checks++;
    if ({battle_lost, battle_won, battle_active, dmg_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL lost_state: lost/won/active/valid got %b expected 1010",
               {battle_lost, battle_won, battle_active, dmg_valid});
    end
    key_in = 8'h29; key_valid = 1'b1;
    tick();  // IDLE
    key_valid = 1'b0;
    hp_player = 8'd100;
    checks++;
    if (all_o !== 21'd0) begin
      errors++;
      $display("FAIL lost_ack_idle: got %h expected 000000", all_o);
    end
  endtask

  task automatic test_async_reset();
    logic hit;
    test_battle_start(1'b0);
    key_in = 8'h16; key_valid = 1'b1; dmg_ready = 1'b0;
    tick();  // P_REQ held
    key_valid = 1'b0;
    checks++;
    if (dmg_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_precond: dmg_valid got %b expected 1", dmg_valid);
    end
    #2 rst = 1'b1;
    #1;  // well before the next rising edge
    checks++;
    if (all_o !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000000", all_o);
    end
    tick();
    rst = 1'b0;
    dmg_ready = 1'b1;
    tick();
    col_e = 1'b1;
    tick();  // INIT
    checks++;
    if ({init_valid, battle_active} !== 2'b11) begin
      errors++;
      $display("FAIL rst_restart: init/active got %b expected 11", {init_valid, battle_active});
    end
    col_e = 1'b0;
    tick();  // SETTLE_I
    tick();  // P_WAIT
    hit = m_lfsr[0];
    key_in = 8'h26; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    checks++;
    if ({dmg_valid, p_attack} !== (hit ? 4'b1011 : 4'b0000)) begin
      errors++;
      $display("FAIL atk3_after_reset: valid/p_attack got %b/%0d expected %b/%0d",
               dmg_valid, p_attack, hit, hit ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_battle_start(1'b1);
    test_player_attack1();
    test_backpressure();
    test_miss();
    test_win();
    test_lose();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_battle_turn_ctrl
`default_nettype wire
